// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises a multi-byte word as back-to-back 8N1 frames,
// most significant byte first.
module uart_word_tx #(
  parameter int CLK_FREQ  = 200000000,
  parameter int UART_BPS  = 115200,
  parameter int DATAWIDTH = 16,
  parameter int CNT_NUM   = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 tx_en,
  input  logic [DATAWIDTH-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 uart_txd
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int BW = (CNT_NUM > 1) ? $clog2(CNT_NUM) : 1;
  localparam logic [CW-1:0] BIT_MAX = CW'(BPS_CNT - 1);
  localparam logic [BW-1:0] BYTE_MAX = BW'(CNT_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_d;
  logic [CW-1:0]        bit_cnt, bit_d;
  logic [2:0]           data_cnt, data_d;
  logic [BW-1:0]        byte_cnt, byte_d;
  logic [DATAWIDTH-1:0] word, word_d;
  logic [7:0]           byte_sel;
  logic                 txd_d;
  logic                 bit_last;
  logic                 byte_last;
  logic                 accept;

  assign bit_last  = (bit_cnt == BIT_MAX);
  assign byte_last = (byte_cnt == BYTE_MAX);

  // Last clock of the final stop bit: the port frees up here so a new
  // request is taken at the very edge that ends the word.
  assign tx_done = (state == STOP) && bit_last && byte_last;
  assign tx_busy = (state != IDLE) && !tx_done;
  assign accept  = tx_en && !tx_busy;

  always_comb begin
    state_d = state;
    bit_d   = bit_cnt;
    data_d  = data_cnt;
    byte_d  = byte_cnt;
    word_d  = word;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = START;
          word_d  = tx_data;
          bit_d   = '0;
          data_d  = '0;
          byte_d  = '0;
        end
      end
      START: begin
        if (bit_last) begin
          bit_d   = '0;
          state_d = DATA;
        end else begin
          bit_d = bit_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_last) begin
          bit_d = '0;
          if (data_cnt == 3'd7) begin
            data_d  = '0;
            state_d = STOP;
          end else begin
            data_d = data_cnt + 3'd1;
          end
        end else begin
          bit_d = bit_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_last) begin
          bit_d = '0;
          if (byte_last) begin
            byte_d = '0;
            if (accept) begin
              state_d = START;
              word_d  = tx_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            byte_d  = byte_cnt + 1'b1;
            state_d = START;
          end
        end else begin
          bit_d = bit_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line value is derived from the next state so it is registered
  // yet aligned with the bit period it belongs to.
  always_comb begin
    byte_sel = '0;
    for (int k = 0; k < CNT_NUM; k++) begin
      if (byte_d == BW'(k)) byte_sel = word_d[DATAWIDTH-1-8*k -: 8];
    end
  end

  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = byte_sel[data_d];
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      data_cnt <= '0;
      byte_cnt <= '0;
      word     <= '0;
      uart_txd <= 1'b1;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_d;
      data_cnt <= data_d;
      byte_cnt <= byte_d;
      word     <= word_d;
      uart_txd <= txd_d;
    end
  end

endmodule
